move_sequencer: RTL



---
 rtl/move_sequencer_pkg.sv | 45 ++++
 rtl/move_sequencer_profile_rom.sv | 43 ++++
 rtl/move_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_pkg.sv
// move_pkg: shared definitions for the runner's vertical-move sequencer.
//   - move codes driven on move_sequencer.move
//   - profile lengths per move
//   - FSM state constants (legacy two-bit encodings)
//   - default y-boundary limits
//   - helpers for move priority and the per-move y guard
package move_pkg;

  localparam logic [1:0] MOVE_IDLE  = 2'b00;
  localparam logic [1:0] MOVE_CLIMB = 2'b01;
  localparam logic [1:0] MOVE_JUMP  = 2'b10;
  localparam logic [1:0] MOVE_DROP  = 2'b11;

  localparam logic [3:0] LEN_CLIMB = 4'd8;
  localparam logic [3:0] LEN_JUMP  = 4'd14;
  localparam logic [3:0] LEN_DROP  = 4'd8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [6:0] Y_TOP_DEFAULT = 7'd40;
  localparam logic [6:0] Y_BOT_DEFAULT = 7'd80;

  // req is active-high, one bit per move: [0] climb, [1] jump, [2] drop.
  // Lower move code wins.
  function automatic logic [1:0] pick_move(input logic [2:0] req);
    if (req[0])      return MOVE_CLIMB;
    else if (req[1]) return MOVE_JUMP;
    else if (req[2]) return MOVE_DROP;
    else             return MOVE_IDLE;
  endfunction

  // Level-boundary gate: climb needs headroom above, drop needs room below.
  function automatic logic guard_ok(input logic [1:0] mv, input logic [6:0] y,
                                    input logic [6:0] top, input logic [6:0] bot);
    case (mv)
      MOVE_CLIMB: return y > top;
      MOVE_JUMP:  return 1'b1;
      MOVE_DROP:  return y < bot;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/move_sequencer_profile_rom.sv
// move_profile_rom: combinational step-profile lookup.
//   i_move  in  2  move code (MOVE_*)
//   i_idx   in  4  step index within the profile
//   o_up    out 1  1 = step moves y up (y decreases)
//   o_mag   out 4  step magnitude 1..9
//   o_last  out 1  entry is the final step of the profile
// Profiles: climb up 9..3 then down 2; jump up 7..1 then down 1..7;
// drop down 1,2,3,4,6,7,8,9.
module move_profile_rom
  import move_pkg::*;
(
  input  logic [1:0] i_move,
  input  logic [3:0] i_idx,
  output logic       o_up,
  output logic [3:0] o_mag,
  output logic       o_last
);

  always_comb begin
    o_up   = 1'b0;
    o_mag  = '0;
    o_last = 1'b0;
    case (i_move)
      MOVE_CLIMB: begin
        o_up   = (i_idx < 4'd7);
        o_mag  = (i_idx < 4'd7) ? (4'd9 - i_idx) : 4'd2;
        o_last = (i_idx == LEN_CLIMB - 4'd1);
      end
      MOVE_JUMP: begin
        o_up   = (i_idx < 4'd7);
        o_mag  = (i_idx < 4'd7) ? (4'd7 - i_idx) : (i_idx - 4'd6);
        o_last = (i_idx == LEN_JUMP - 4'd1);
      end
      MOVE_DROP: begin
        // magnitude 5 is skipped
        o_mag  = (i_idx < 4'd4) ? (i_idx + 4'd1) : (i_idx + 4'd2);
        o_last = (i_idx == LEN_DROP - 4'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: picks one vertical move at a time from the active-low move
// keys and paces its step profile against frame_tick.
//   clk         in  1  system clock
//   reset       in  1  synchronous, active-high
//   frame_tick  in  1  one-cycle pulse per frame
//   keys        in  3  active-low: [0] climb, [1] jump, [2] drop
//   man_style   in  1  new move starts permitted when high
//   y           in  7  current y from the datapath (0 = top)
//   move        out 2  active move code
//   busy        out 1  move in progress
//   step_valid  out 1  one-cycle step strobe
//   step_up     out 1  step direction (valid with step_valid)
//   step_mag    out 4  step magnitude (valid with step_valid)
//   done        out 1  one-cycle pulse after the last step
// Build option: MOVE_QUEUE_EN adds a one-deep pending request captured on key
// falling edges while busy, launched from the FINISH cycle.
module move_sequencer
  import move_pkg::*;
#(
  parameter int unsigned FRAME_DIV   = 1,
  parameter logic [6:0]  Y_TOP_LIMIT = Y_TOP_DEFAULT,
  parameter logic [6:0]  Y_BOT_LIMIT = Y_BOT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] keys,
  input  logic       man_style,
  input  logic [6:0] y,
  output logic [1:0] move,
  output logic       busy,
  output logic       step_valid,
  output logic       step_up,
  output logic [3:0] step_mag,
  output logic       done
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  logic [1:0] r_state;
  logic [1:0] r_move;
  logic       r_busy;
  logic [3:0] r_div;
  logic [3:0] r_idx;
  logic       r_step_valid;
  logic       r_step_up;
  logic [3:0] r_step_mag;
  logic       r_step_last;
  logic       r_done;

  logic [2:0] w_req;
  logic [1:0] w_start_move;
  logic [1:0] w_next_move;
  logic       w_rom_up;
  logic [3:0] w_rom_mag;
  logic       w_rom_last;

  assign w_req = ~keys & {guard_ok(MOVE_DROP,  y, Y_TOP_LIMIT, Y_BOT_LIMIT),
                          1'b1,
                          guard_ok(MOVE_CLIMB, y, Y_TOP_LIMIT, Y_BOT_LIMIT)};
  assign w_start_move = pick_move(w_req);

  move_profile_rom u_rom (
    .i_move (r_move),
    .i_idx  (r_idx),
    .o_up   (w_rom_up),
    .o_mag  (w_rom_mag),
    .o_last (w_rom_last)
  );

`ifdef MOVE_QUEUE_EN
  logic [2:0] r_keys_q;
  logic [1:0] r_pend;
  logic [1:0] w_edge_move;

  assign w_edge_move = pick_move(r_keys_q & ~keys);
  // Pending request is re-checked against y only when it would launch.
  assign w_next_move = guard_ok(r_pend, y, Y_TOP_LIMIT, Y_BOT_LIMIT) ? r_pend : MOVE_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_keys_q <= '1;
      r_pend   <= MOVE_IDLE;
    end else begin
      r_keys_q <= keys;
      if (r_state == ST_FINISH)
        r_pend <= MOVE_IDLE;
      else if (r_busy && (w_edge_move != MOVE_IDLE) &&
               ((r_pend == MOVE_IDLE) || (w_edge_move < r_pend)))
        r_pend <= w_edge_move;
    end
  end
`else
  assign w_next_move = MOVE_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_move       <= MOVE_IDLE;
      r_busy       <= 1'b0;
      r_div        <= '0;
      r_idx        <= '0;
      r_step_valid <= 1'b0;
      r_step_up    <= 1'b0;
      r_step_mag   <= '0;
      r_step_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_step_valid <= 1'b0;
      r_step_up    <= 1'b0;
      r_step_mag   <= '0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (man_style && (w_start_move != MOVE_IDLE)) begin
            r_move  <= w_start_move;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_div   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // FINISH is entered one cycle after the last strobe so that done
          // lands the cycle after it and busy drops the cycle after done.
          if (r_step_valid && r_step_last) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end else if (frame_tick) begin
            if (r_div == DIV_LAST) begin
              r_div        <= '0;
              r_step_valid <= 1'b1;
              r_step_up    <= w_rom_up;
              r_step_mag   <= w_rom_mag;
              r_step_last  <= w_rom_last;
              r_idx        <= r_idx + 4'd1;
            end else begin
              r_div <= r_div + 4'd1;
            end
          end
        end
        ST_FINISH: begin
          r_idx       <= '0;
          r_div       <= '0;
          r_step_last <= 1'b0;
          if (w_next_move != MOVE_IDLE) begin
            r_move  <= w_next_move;
            r_state <= ST_RUN;
          end else begin
            r_move  <= MOVE_IDLE;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move       = r_move;
  assign busy       = r_busy;
  assign step_valid = r_step_valid;
  assign step_up    = r_step_up;
  assign step_mag   = r_step_mag;
  assign done       = r_done;

endmodule
